// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with a two-flop synchroniser,
// 3-sample majority voting and per-frame parity/framing/break flags.
// Received frames are buffered in a small FIFO behind a valid/ready port.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   rx              asynchronous serial line, idle high
//   m_data/m_perr/m_ferr/m_brk  registered head-of-FIFO frame fields
//   m_valid         FIFO non-empty; m_ready pops the head entry
//   overrun         sticky drop flag, cleared by overrun_clr
//   busy            receiver FSM is not idle
module uart_rx_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_perr,
  output logic                 m_ferr,
  output logic                 m_brk,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int MID = CPB / 2;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = DATA_BITS + 3;

  generate
    if (CPB < 8) begin : g_cpb_chk
      $error("uart_rx_param: CLK_FREQ/BAUD_RATE must be at least 8");
    end
  endgenerate

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_WAITH = 3'd5;

  logic                 rx_m_q, rx_s_q;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 samp_a_q, samp_a_d, samp_b_q, samp_b_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d, par_bit_q, par_bit_d;
  logic                 push, ferr, brk, vote, wrap, at_dec, exp_par;
  logic [EW-1:0]        ent;

  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          fcnt_q, fcnt_d, avail;
  logic                 pop, full, wr_en, drop;
  logic                 m_valid_q, m_valid_d, overrun_q, overrun_d;
  logic [EW-1:0]        head_q, head_d;

  assign wrap    = cnt_q == CW'(CPB - 1);
  assign at_dec  = cnt_q == CW'(MID + 1);
  // majority of the samples taken at MID-1, MID and the current one at MID+1
  assign vote    = (samp_a_q & samp_b_q) | (samp_a_q & rx_s_q) | (samp_b_q & rx_s_q);
  assign exp_par = (PARITY == 2) ? ~^data_q : ^data_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = wrap ? '0 : cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    samp_a_d   = (cnt_q == CW'(MID - 1)) ? rx_s_q : samp_a_q;
    samp_b_d   = (cnt_q == CW'(MID))     ? rx_s_q : samp_b_q;
    data_d     = data_q;
    perr_d     = perr_q;
    par_bit_d  = par_bit_q;
    push       = 1'b0;
    ferr       = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        data_d    = '0;
        perr_d    = 1'b0;
        par_bit_d = 1'b0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (at_dec && vote) state_d = S_IDLE;
        else if (wrap) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        // shift in from the top so the first bit ends up at the LSB
        if (at_dec) data_d = {vote, data_q[DATA_BITS-1:1]};
        if (wrap) begin
          if (bit_idx_q == 4'(DATA_BITS - 1)) begin
            state_d    = (PARITY != 0) ? S_PAR : S_STOP;
            stop_idx_d = 1'b0;
          end else bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      S_PAR: begin
        if (at_dec) begin
          par_bit_d = vote;
          perr_d    = vote != exp_par;
        end
        if (wrap) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
        end
      end
      S_STOP: begin
        if (at_dec) begin
          if (!vote) begin
            push    = 1'b1;
            ferr    = 1'b1;
            state_d = S_WAITH;  // hold off until the line goes idle again
          end else if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end else if (wrap) stop_idx_d = 1'b1;
      end
      S_WAITH: if (rx_s_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign brk = ferr & (data_q == '0) & ((PARITY == 0) | !par_bit_q);
  assign ent = {brk, ferr, perr_q, data_q};

  // Output registers track the head after this cycle's pop but ignore this
  // cycle's push, so a freshly written entry appears one edge after commit.
  always_comb begin
    pop       = m_valid_q & m_ready;
    full      = fcnt_q == (AW+1)'(FIFO_DEPTH);
    wr_en     = push & (!full | pop);
    drop      = push & full & !pop;
    wr_ptr_d  = wr_ptr_q + AW'(wr_en);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    fcnt_d    = fcnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    avail     = fcnt_q - (AW+1)'(pop);
    m_valid_d = avail != '0;
    head_d    = m_valid_d ? mem_q[rd_ptr_d] : '0;
    overrun_d = drop | (overrun_q & !overrun_clr);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= ent;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m_q     <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      samp_a_q   <= 1'b1;
      samp_b_q   <= 1'b1;
      data_q     <= '0;
      perr_q     <= 1'b0;
      par_bit_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
      m_valid_q  <= 1'b0;
      head_q     <= '0;
      overrun_q  <= 1'b0;
    end else begin
      rx_m_q     <= rx;
      rx_s_q     <= rx_m_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      samp_a_q   <= samp_a_d;
      samp_b_q   <= samp_b_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      par_bit_q  <= par_bit_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
      m_valid_q  <= m_valid_d;
      head_q     <= head_d;
      overrun_q  <= overrun_d;
    end
  end

  assign {m_brk, m_ferr, m_perr, m_data} = head_q;
  assign m_valid = m_valid_q;
  assign overrun = overrun_q;
  assign busy    = state_q != S_IDLE;
endmodule
